// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - load-use stall, branch flush, freeze and registered forwarding selects (optional counters: HAZARD_PERF_EN)
module hazard_ctrl #(
    parameter int ASIZE = 5,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             id_valid,
    input  logic [ASIZE-1:0] id_rs1,
    input  logic [ASIZE-1:0] id_rs2,
    input  logic             id_uses_rs2,
    input  logic             id_wen,
    input  logic             id_mem_read,
    input  logic [ASIZE-1:0] id_waddr,
    input  logic             exe_branch_taken,
    input  logic             exe_busy,
    output logic             stall_if,
    output logic             bubble_ex,
    output logic             flush_id,
    output logic             hold_ex,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    typedef enum logic {
        RUN,
        FREEZE
    } state_t;

    typedef struct packed {
        logic             wen;
        logic             mem_read;
        logic [ASIZE-1:0] waddr;
    } shadow_t;

    localparam logic [1:0] SEL_RF  = 2'b00;
    localparam logic [1:0] SEL_MEM = 2'b01;
    localparam logic [1:0] SEL_WB  = 2'b10;

    state_t  state;
    state_t  state_nxt;
    shadow_t ex_q;
    shadow_t mem_q;
    shadow_t ex_nxt;

    logic       load_use;
    logic       advance;
    logic       run_stall;
    logic       run_bubble;
    logic       run_flush;
    logic [1:0] fwd_a_nxt;
    logic [1:0] fwd_b_nxt;

    // A load still in EXE has no result yet, so only an ALU producer there can forward.
    function automatic logic [1:0] fwd_sel(input logic [ASIZE-1:0] rs,
                                           input shadow_t ex,
                                           input shadow_t mem);
        logic [1:0] sel;
        sel = SEL_RF;
        if (rs != '0) begin
            if (ex.wen && !ex.mem_read && (ex.waddr == rs)) begin
                sel = SEL_MEM;
            end else if (mem.wen && (mem.waddr == rs)) begin
                sel = SEL_WB;
            end
        end
        return sel;
    endfunction

    always_comb begin
        load_use = 1'b0;
        if (id_valid && ex_q.wen && ex_q.mem_read && (ex_q.waddr != '0)) begin
            load_use = (ex_q.waddr == id_rs1) ||
                       (id_uses_rs2 && (ex_q.waddr == id_rs2));
        end
    end

    always_comb begin
        run_flush  = exe_branch_taken;
        run_stall  = !exe_branch_taken && load_use;
        run_bubble = exe_branch_taken || load_use;
    end

    // The busy unit cannot accept its successor, so the front end holds from the first busy cycle.
    always_comb begin
        state_nxt = state;
        stall_if  = 1'b0;
        bubble_ex = 1'b0;
        flush_id  = 1'b0;
        hold_ex   = 1'b0;
        advance   = 1'b0;
        case (state)
            RUN: begin
                if (exe_busy) begin
                    state_nxt = FREEZE;
                    stall_if  = 1'b1;
                    hold_ex   = 1'b1;
                end else begin
                    advance   = 1'b1;
                    stall_if  = run_stall;
                    bubble_ex = run_bubble;
                    flush_id  = run_flush;
                end
            end
            FREEZE: begin
                if (exe_busy) begin
                    stall_if = 1'b1;
                    hold_ex  = 1'b1;
                end else begin
                    state_nxt = RUN;
                    advance   = 1'b1;
                    stall_if  = run_stall;
                    bubble_ex = run_bubble;
                    flush_id  = run_flush;
                end
            end
            default: begin
                state_nxt = RUN;
            end
        endcase
        if (!rst_n) begin
            stall_if  = 1'b0;
            bubble_ex = 1'b0;
            flush_id  = 1'b0;
            hold_ex   = 1'b0;
            advance   = 1'b0;
        end
    end

    always_comb begin
        ex_nxt = '0;
        if (!bubble_ex) begin
            ex_nxt.wen      = id_wen & id_valid;
            ex_nxt.mem_read = id_mem_read;
            ex_nxt.waddr    = id_waddr;
        end
    end

    always_comb begin
        fwd_a_nxt = SEL_RF;
        fwd_b_nxt = SEL_RF;
        if (!bubble_ex) begin
            fwd_a_nxt = fwd_sel(id_rs1, ex_q, mem_q);
            if (id_uses_rs2) begin
                fwd_b_nxt = fwd_sel(id_rs2, ex_q, mem_q);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= RUN;
            ex_q  <= '0;
            mem_q <= '0;
            fwd_a <= SEL_RF;
            fwd_b <= SEL_RF;
        end else begin
            state <= state_nxt;
            if (advance) begin
                mem_q <= ex_q;
                ex_q  <= ex_nxt;
                fwd_a <= fwd_a_nxt;
                fwd_b <= fwd_b_nxt;
            end
        end
    end

`ifdef HAZARD_PERF_EN
    logic [CNT_W-1:0] stall_q;
    logic [CNT_W-1:0] flush_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            if (advance && run_stall && (stall_q != '1)) begin
                stall_q <= stall_q + CNT_W'(1);
            end
            if (advance && run_flush && (flush_q != '1)) begin
                flush_q <= flush_q + CNT_W'(1);
            end
        end
    end

    assign stall_cnt = stall_q;
    assign flush_cnt = flush_q;
`else
    assign stall_cnt = '0;
    assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - directed self-checking bench for hazard_ctrl
module tb_hazard_ctrl;

    localparam int ASIZE = 5;
    localparam int CNT_W = 16;
`ifdef HAZARD_PERF_EN
    localparam int PERF = 1;
`else
    localparam int PERF = 0;
`endif

    logic             clk = 1'b0;
    logic             rst_n;
    logic             id_valid;
    logic [ASIZE-1:0] id_rs1;
    logic [ASIZE-1:0] id_rs2;
    logic             id_uses_rs2;
    logic             id_wen;
    logic             id_mem_read;
    logic [ASIZE-1:0] id_waddr;
    logic             exe_branch_taken;
    logic             exe_busy;
    logic             stall_if;
    logic             bubble_ex;
    logic             flush_id;
    logic             hold_ex;
    logic [1:0]       fwd_a;
    logic [1:0]       fwd_b;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    int total  = 0;
    int passed = 0;

    hazard_ctrl #(.ASIZE(ASIZE), .CNT_W(CNT_W)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .id_valid         (id_valid),
        .id_rs1           (id_rs1),
        .id_rs2           (id_rs2),
        .id_uses_rs2      (id_uses_rs2),
        .id_wen           (id_wen),
        .id_mem_read      (id_mem_read),
        .id_waddr         (id_waddr),
        .exe_branch_taken (exe_branch_taken),
        .exe_busy         (exe_busy),
        .stall_if         (stall_if),
        .bubble_ex        (bubble_ex),
        .flush_id         (flush_id),
        .hold_ex          (hold_ex),
        .fwd_a            (fwd_a),
        .fwd_b            (fwd_b),
        .stall_cnt        (stall_cnt),
        .flush_cnt        (flush_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic ctl(input string tag, input logic s, input logic b, input logic f, input logic h);
        #1;
        check({tag, ".stall_if"}, 32'(stall_if), 32'(s));
        check({tag, ".bubble_ex"}, 32'(bubble_ex), 32'(b));
        check({tag, ".flush_id"}, 32'(flush_id), 32'(f));
        check({tag, ".hold_ex"}, 32'(hold_ex), 32'(h));
    endtask

    task automatic fwd(input string tag, input logic [1:0] a, input logic [1:0] b);
        check({tag, ".fwd_a"}, 32'(fwd_a), 32'(a));
        check({tag, ".fwd_b"}, 32'(fwd_b), 32'(b));
    endtask

    task automatic instr(input logic wen, input logic mrd, input logic [ASIZE-1:0] wa,
                         input logic [ASIZE-1:0] r1, input logic [ASIZE-1:0] r2, input logic u2);
        id_valid    = 1'b1;
        id_wen      = wen;
        id_mem_read = mrd;
        id_waddr    = wa;
        id_rs1      = r1;
        id_rs2      = r2;
        id_uses_rs2 = u2;
    endtask

    initial begin
        rst_n = 1'b0;
        exe_busy = 1'b1;
        exe_branch_taken = 1'b1;
        instr(1'b1, 1'b1, 5'd3, 5'd3, 5'd3, 1'b1);
        ctl("rst_comb", 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        fwd("rst", 2'b00, 2'b00);
        check("rst.stall_cnt", 32'(stall_cnt), 32'd0);
        check("rst.flush_cnt", 32'(flush_cnt), 32'd0);

        rst_n = 1'b1;
        exe_busy = 1'b0;
        exe_branch_taken = 1'b0;
        instr(1'b1, 1'b1, 5'd3, 5'd1, 5'd2, 1'b0);
        ctl("load_issue", 1'b0, 1'b0, 1'b0, 1'b0);
        step();

        instr(1'b1, 1'b0, 5'd4, 5'd3, 5'd0, 1'b0);
        ctl("load_use", 1'b1, 1'b1, 1'b0, 1'b0);
        step();
        fwd("load_use_bubble", 2'b00, 2'b00);
        ctl("load_use_once", 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        fwd("load_use_fwd", 2'b10, 2'b00);
        check("load_use.stall_cnt", 32'(stall_cnt), 32'(PERF));

        instr(1'b1, 1'b0, 5'd5, 5'd0, 5'd0, 1'b1);
        ctl("add", 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        fwd("add_x0_src", 2'b00, 2'b00);
        instr(1'b1, 1'b0, 5'd6, 5'd5, 5'd5, 1'b1);
        ctl("sub", 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        fwd("alu_chain", 2'b01, 2'b01);

        instr(1'b1, 1'b0, 5'd0, 5'd9, 5'd9, 1'b1);
        step();
        instr(1'b1, 1'b0, 5'd7, 5'd0, 5'd0, 1'b1);
        step();
        fwd("x0_no_fwd", 2'b00, 2'b00);
        instr(1'b1, 1'b0, 5'd7, 5'd8, 5'd8, 1'b1);
        step();
        instr(1'b1, 1'b0, 5'd10, 5'd7, 5'd7, 1'b0);
        step();
        fwd("ex_beats_mem", 2'b01, 2'b00);
        instr(1'b1, 1'b0, 5'd11, 5'd7, 5'd10, 1'b1);
        step();
        fwd("mem_and_ex", 2'b10, 2'b01);

        instr(1'b1, 1'b1, 5'd12, 5'd0, 5'd0, 1'b0);
        step();
        instr(1'b1, 1'b0, 5'd13, 5'd12, 5'd0, 1'b0);
        exe_branch_taken = 1'b1;
        ctl("branch_prio", 1'b0, 1'b1, 1'b1, 1'b0);
        step();
        exe_branch_taken = 1'b0;
        fwd("branch_bubble", 2'b00, 2'b00);
        check("branch.flush_cnt", 32'(flush_cnt), 32'(PERF));
        check("branch.stall_cnt", 32'(stall_cnt), 32'(PERF));

        instr(1'b1, 1'b0, 5'd14, 5'd12, 5'd0, 1'b0);
        ctl("pre_freeze", 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        fwd("pre_freeze", 2'b10, 2'b00);
        exe_busy = 1'b1;
        instr(1'b1, 1'b0, 5'd15, 5'd14, 5'd14, 1'b1);
        ctl("freeze1", 1'b1, 1'b0, 1'b0, 1'b1);
        step();
        fwd("freeze1", 2'b10, 2'b00);
        exe_branch_taken = 1'b1;
        ctl("freeze2_branch", 1'b1, 1'b0, 1'b0, 1'b1);
        step();
        exe_branch_taken = 1'b0;
        fwd("freeze2", 2'b10, 2'b00);
        ctl("freeze3", 1'b1, 1'b0, 1'b0, 1'b1);
        step();
        fwd("freeze3", 2'b10, 2'b00);
        exe_busy = 1'b0;
        ctl("unfreeze", 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        fwd("shadow_held", 2'b01, 2'b01);
        check("freeze.flush_cnt", 32'(flush_cnt), 32'(PERF));

        instr(1'b1, 1'b1, 5'd16, 5'd0, 5'd0, 1'b0);
        step();
        exe_busy = 1'b1;
        instr(1'b1, 1'b0, 5'd17, 5'd16, 5'd0, 1'b0);
        ctl("freeze_load", 1'b1, 1'b0, 1'b0, 1'b1);
        step();
        rst_n = 1'b0;
        ctl("rst_in_freeze", 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        fwd("rst_in_freeze", 2'b00, 2'b00);
        check("rst2.stall_cnt", 32'(stall_cnt), 32'd0);
        check("rst2.flush_cnt", 32'(flush_cnt), 32'd0);
        rst_n = 1'b1;
        exe_busy = 1'b0;
        ctl("post_rst_no_stale", 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        fwd("post_rst_no_stale", 2'b00, 2'b00);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Hazard and forwarding controller for the 5-stage pipeline. It tracks destination registers of in-flight instructions and gates the decode-to-execute pipeline register from the consuming side. Outputs:
- Load-use stalls and bubbles into the ID/EXE register.
- Branch flushes of IF/ID.
- Registered forwarding selects, aligned with the operands the execute stage reads.

It sits beside the ID/EXE register, between decode and execute.

## Interface
Parameters:
- ASIZE, 5, register-address width
- CNT_W, 16, performance counter width

Ports:
- clk  in  1  clock; all state updates on posedge
- rst_n  in  1  synchronous, active-low reset
- id_valid  in  1  decode holds a real instruction
- id_rs1  in  ASIZE  source register 1 of instruction in ID
- id_rs2  in  ASIZE  source register 2 of instruction in ID
- id_uses_rs2  in  1  rs2 is read; R-type and store
- id_wen  in  1  instruction in ID writes the register file
- id_mem_read  in  1  instruction in ID is a load
- id_waddr  in  ASIZE  destination register of instruction in ID
- exe_branch_taken  in  1  branch in EXE resolved taken this cycle
- exe_busy  in  1  multicycle EXE unit not ready; freezes front end
- stall_if  out  1  hold PC and IF/ID this cycle
- bubble_ex  out  1  load NOP into ID/EXE: wen, branch, mem_write, mem_read forced 0
- flush_id  out  1  replace IF/ID contents with NOP
- hold_ex  out  1  ID/EXE keeps its current contents
- fwd_a  out  2  ALU operand 1 source: 00 regfile, 01 EXE/MEM result, 10 MEM/WB result
- fwd_b  out  2  ALU operand 2 (rdata2) source, same encoding
- stall_cnt  out  CNT_W  load-use stall cycles
- flush_cnt  out  CNT_W  taken-branch flushes

## Operation
- Shadow entries, each {wen, mem_read, waddr}:
  - EX: the instruction now in EXE.
  - MEM: the instruction now in MEM.
- An entry with waddr = 0 never matches any source register.
- Load-use hazard (combinational):
  - All of: EX.mem_read, EX.wen, EX.waddr ≠ 0, id_valid.
  - And either EX.waddr = id_rs1, or (id_uses_rs2 and EX.waddr = id_rs2).
- FSM states RUN and FREEZE.
- RUN:
  - exe_branch_taken → flush_id = 1, bubble_ex = 1, stall_if = 0. Has priority over load-use.
  - Else load-use → stall_if = 1, bubble_ex = 1.
  - Else all control outputs 0.
  - exe_busy = 1 → enter FREEZE.
- FREEZE:
  - stall_if = 1, hold_ex = 1, bubble_ex = 0, flush_id = 0.
  - Shadow entries and fwd_a/fwd_b hold.
  - exe_branch_taken is ignored.
  - Leave to RUN on the first cycle exe_busy = 0; that cycle is evaluated as RUN.
- Shadow update in RUN:
  - MEM ← EX.
  - EX ← bubble_ex ? 0 : {id_wen & id_valid, id_mem_read, id_waddr}.
- Forwarding, registered at each RUN edge for the operand now in ID. Per source rs:
  - 01 if EX.wen, EX.waddr = rs ≠ 0, and !EX.mem_read.
  - Else 10 if MEM.wen and MEM.waddr = rs ≠ 0.
  - Else 00.
  - EX match beats MEM match.
  - fwd_b is evaluated only when id_uses_rs2; otherwise it is 00.
  - bubble_ex → both next selects 00.
- Register-file write and read of the same register in the same cycle is resolved by the register file (write-first). No WB forwarding here.

## Timing
- Reset, on the first posedge with rst_n = 0:
  - State RUN.
  - Shadow entries all 0.
  - fwd_a = fwd_b = 00.
  - Counters 0.
  - While rst_n = 0, stall_if, bubble_ex, flush_id and hold_ex are forced 0.
- Combinational outputs (stall_if, bubble_ex, flush_id, hold_ex) resolve in the same cycle as their inputs.
- Load-use stall lasts exactly one cycle. Next cycle the load is in MEM and the consumer gets fwd = 10 when it enters EXE.
- Branch flush lasts one cycle: the IF/ID and ID/EXE slots of the two younger instructions are killed.
- fwd_a/fwd_b change only on RUN edges and are valid throughout the consumer's EXE cycle.
- Reset mid-stall or mid-FREEZE: returns to RUN with empty shadow; no stale forwarding.

## Configuration
- HAZARD_PERF_EN defined:
  - stall_cnt increments once per RUN cycle with load-use stall asserted.
  - flush_cnt increments once per taken-branch flush.
  - Both saturate at all-ones.
- Undefined: no counter logic; stall_cnt and flush_cnt tie to 0.

## Test plan
- Load-use: EX = {wen 1, mem_read 1, waddr 3}, ID rs1 = 3 → stall_if = 1, bubble_ex = 1 for one cycle; next edge fwd_a = 10; stall_cnt = 1 with the macro.
- ALU chain: add r5 then sub r6, r5, r5 → no stall; fwd_a = fwd_b = 01 during sub's EXE.
- x0 and priority: producer writes r0 → fwd = 00. Producers to r7 in EX and in MEM → fwd = 01.
- Branch: exe_branch_taken = 1 coinciding with a load-use condition → flush_id = 1, bubble_ex = 1, stall_if = 0; flush_cnt = 1.
- Freeze: exe_busy high for 3 cycles → stall_if = hold_ex = 1 each cycle; fwd and shadow unchanged; a branch_taken pulse is ignored.
- Reset: rst_n low during FREEZE → next cycle all outputs 0, fwd = 00, counters 0.
